sram_mem_controller: RTL

Memory-stage responder for the load/store requests that leave the execute stage of the ARM pipeline. It accepts a 32-bit word read or write (memory read enable / memory write enable plus an address) and performs it as two 16-bit accesses to an external asynchronous SRAM, low half first. While an access is in progress it deasserts ready, and the hazard/freeze logic uses that signal to stall every pipeline register.

---
 rtl/sram_mem_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - 32-bit load/store performed as two 16-bit async SRAM accesses, low half first
// Optional out-of-range trap enabled by defining SRAM_BOUNDS_CHECK_EN.
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdEn,
    input  logic               wrEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic               addrErr,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 op_wr;
    logic [SRAM_AW-2:0]   word_lat;
    logic [31:0]          wdata_lat;
    logic [31:0]          read_data;
    logic                 addr_err;

    logic [31:0]          off;
    logic [SRAM_AW-2:0]   word_in;
    logic                 req;
    logic                 half_end;
    logic                 range_err;
    logic                 wr_phase;
    logic                 unused_off;

    assign off        = address - 32'(BASE_ADDR);
    assign word_in    = off[SRAM_AW:2];
    assign req        = rdEn | wrEn;
    assign half_end   = (cnt == CNT_LAST);
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_BOUNDS_CHECK_EN
    assign range_err = (address < 32'(BASE_ADDR)) || (off[31:SRAM_AW+1] != '0);
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_n   = '0;
                    state_n = range_err ? DONE : LOW;
                end
            end
            LOW: begin
                if (half_end) begin
                    cnt_n   = '0;
                    state_n = HIGH;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (half_end) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Op/address/data are captured once so a request dropped mid-access still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr     <= 1'b0;
            word_lat  <= '0;
            wdata_lat <= '0;
            read_data <= '0;
            addr_err  <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (state == IDLE && req) begin
                if (range_err) begin
                    read_data <= '0;
                    addr_err  <= 1'b1;
                end else begin
                    op_wr     <= wrEn;
                    word_lat  <= word_in;
                    wdata_lat <= writeData;
                end
            end
            if (!op_wr && half_end) begin
                if (state == LOW)  read_data[15:0]  <= SRAM_DQ;
                if (state == HIGH) read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    assign wr_phase  = op_wr && (state == LOW || state == HIGH);
    assign SRAM_DQ   = wr_phase ? ((state == HIGH) ? wdata_lat[31:16] : wdata_lat[15:0]) : 'z;
    assign SRAM_WE_N = ~wr_phase;
    assign SRAM_OE_N = wr_phase;
    assign SRAM_ADDR = {word_lat, (state == HIGH)};
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign readData = read_data;
    assign ready    = ~req | (state == DONE);
    assign addrErr  = addr_err;

endmodule
